spi_nor_responder: RTL and testbench
====================================

# spi_nor_responder

Behavioural-synthesizable SPI NOR flash responder: the slave end of the serial link driven by the team's APB-to-SPI flash controller. It oversamples the SPI pins on the system clock, decodes a standard single-bit NOR command set, and serves an internal byte-wide flash array. It is used as the flash target in controller benches and on FPGA prototypes.

## Interface

- MEM_AW, 10, byte-address width of the internal array (2^MEM_AW bytes); wire addresses above this are truncated.
- PAGE_AW, 8, page size is 2^PAGE_AW bytes; program address wraps inside the page.
- PROG_CYCLES, 64, p_clk cycles WIP stays set after a program command completes.
- p_clk  input  1  system clock; all logic on its rising edge.
- p_rst  input  1  reset; asynchronous, active-high.
- s_clk  input  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0); at most p_clk/8.
- s_css  input  1  chip select, active low.
- s_mosi  input  1  serial data from the master, MSB first.
- s_miso  output  1  serial data to the master, MSB first; driven 0 whenever s_css is high.
- busy  output  1  mirror of status bit WIP.
- cmd_err  output  1  one-cycle pulse on an unsupported opcode.

## Operation

- s_clk, s_css and s_mosi each pass through a 2-flop synchronizer. Rising and falling edges of s_clk and s_css are detected on the synchronized copies.
- On a rising s_clk edge with s_css low, the synchronized s_mosi is shifted into the bit counter and shift register.
- On a falling s_clk edge, the next s_miso bit is shifted out.
- The status register holds WIP in bit 0 and WEL in bit 1. Bits 7:2 read as 0.
- States:
  - IDLE: waits for the falling edge of s_css, then goes to CMD.
  - CMD: collects 8 opcode bits, then decodes:
    - 0x06 WREN: sets WEL.
    - 0x04 WRDI: clears WEL.
    - 0x05 RDSR: goes to STAT_OUT.
    - 0x03 READ: goes to ADDR.
    - 0x02 PP: goes to ADDR, provided WEL=1 and WIP=0; otherwise goes to IGNORE.
    - Any other opcode: pulses cmd_err and goes to IGNORE.
    - While WIP=1, every opcode except 0x05 goes to IGNORE and causes no state change.
  - ADDR: collects a 24-bit address, MSB first, and keeps the low MEM_AW bits. READ then fetches the array byte and goes to DATA_OUT. PP goes to DATA_IN.
  - DATA_OUT: shifts out the byte at the current address, then increments the address. Wraps from 2^MEM_AW-1 to 0. Continues until s_css rises.
  - STAT_OUT: shifts out the status register repeatedly. The value is re-sampled at each byte boundary.
  - DATA_IN: on each completed byte, writes mem[addr] = mem[addr] & byte (flash semantics: bits only go 1 to 0). The page offset (low PAGE_AW bits) then increments with wrap; the upper bits are held. An incomplete trailing byte is discarded.
  - IGNORE: ignores traffic until s_css rises; s_miso stays 0.
- Any rising edge of s_css returns to IDLE and clears the bit counter. If at least one PP data byte was written, WIP is set, a counter is loaded with PROG_CYCLES, and WEL is cleared. When the counter reaches 0, WIP is cleared.
- The array has no reset. Its contents are 0xFF at time zero and are untouched by p_rst.

## Timing

- Reset values: s_miso=0, busy=0, cmd_err=0, state IDLE, WEL=0, WIP=0, counters and shift registers 0.
- Edge detection latency is 3 p_clk cycles from the pin to an internal event.
- The first output bit (MSB) of DATA_OUT or STAT_OUT drives s_miso within 2 p_clk cycles of the detected falling s_clk edge that follows the last command/address bit. It is stable before the next rising s_clk.
- The array read has 1 p_clk latency and is issued on the rising edge that completes the address.
- cmd_err asserts for exactly 1 cycle, 1 cycle after the 8th opcode bit is detected.
- If s_css rising and an s_clk edge are detected in the same cycle, s_css takes priority and the bit is dropped.
- If p_rst is asserted mid-transaction, the block aborts immediately. A pending program aborts with WIP=0. Array bytes already written stay written.
- The WIP countdown decrements every p_clk cycle, independent of SPI activity.

## Test plan

- Reset, then RDSR (0x05) -> s_miso returns 0x00; busy=0.
- WREN, then RDSR -> 0x02. WRDI, then RDSR -> 0x00.
- WREN, then PP to addr 0x000010 with data 0xA5, 0x3C; s_css rises -> busy high for 64 cycles, then RDSR returns 0x00. READ of 0x000010 over 3 bytes -> 0xA5, 0x3C, 0xFF.
- PP to an already-programmed byte (0xA5) with 0x0F -> a subsequent READ returns 0x05. PP without a preceding WREN -> array unchanged, busy stays 0.
- PP starting at 0x0000FE with 3 bytes -> writes land at 0xFE, 0xFF, 0x00 (page wrap). READ starting at 0x0003FF over 2 bytes -> data from 0x3FF, then 0x000 (array wrap).
- Opcode 0xAB -> cmd_err pulses once and s_miso stays 0. READ issued while busy=1 -> s_miso stays 0. p_rst asserted mid-READ -> s_miso=0 and the next command decodes normally.

Source files
------------

// File: rtl/spi_nor_responder.sv
// SPI NOR flash responder: mode-0 slave with oversampled pins serving a byte-wide array.
// Supports the WREN/WRDI/RDSR/READ/PP commands; WIP times out a fixed number of p_clk cycles after a program.
module spi_nor_responder #(
  parameter int MEM_AW      = 10,
  parameter int PAGE_AW     = 8,
  parameter int PROG_CYCLES = 64
) (
  input  logic p_clk,
  input  logic p_rst,
  input  logic s_clk,
  input  logic s_css,
  input  logic s_mosi,
  output logic s_miso,
  output logic busy,
  output logic cmd_err
);
  localparam int CW = $clog2(PROG_CYCLES + 1);
  localparam int SW = (MEM_AW > 8) ? MEM_AW : 8;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_OUT, STAT_OUT, DATA_IN, IGNORE} state_t;

  state_t              state;
  logic [2:0]          clk_sy, css_sy;
  logic [1:0]          mosi_sy;
  logic [4:0]          bit_cnt;
  logic [SW-2:0]       shreg;
  logic [SW-1:0]       shift_nxt;
  logic [7:0]          in_byte, nxt_byte, tx_sr, rd_dat;
  logic [MEM_AW-1:0]   addr;
  logic [CW-1:0]       wip_cnt;
  logic                miso_r, cmd_pp, wel, wip, prog_any;
  logic                sclk_rise, sclk_fall, css_rise, css_fall, mosi_bit, mem_we;

  // Array powers up erased; it is deliberately outside the reset domain.
  logic [7:0] mem [0:(1<<MEM_AW)-1] = '{default: 8'hFF};

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      clk_sy  <= '0;
      css_sy  <= '0;
      mosi_sy <= '0;
    end else begin
      clk_sy  <= {clk_sy[1:0], s_clk};
      css_sy  <= {css_sy[1:0], s_css};
      mosi_sy <= {mosi_sy[0], s_mosi};
    end
  end

  assign sclk_rise = clk_sy[1] & ~clk_sy[2];
  assign sclk_fall = ~clk_sy[1] & clk_sy[2];
  assign css_rise  = css_sy[1] & ~css_sy[2];
  assign css_fall  = ~css_sy[1] & css_sy[2];
  assign mosi_bit  = mosi_sy[1];
  assign shift_nxt = {shreg, mosi_bit};
  assign in_byte   = shift_nxt[7:0];
  assign nxt_byte  = (state == DATA_OUT) ? rd_dat : {6'b0, wel, wip};
  assign mem_we    = sclk_rise && !css_rise && (state == DATA_IN) && (bit_cnt == 5'd7);

  // rd_dat continuously tracks mem[addr]; addr always settles long before the next byte boundary.
  always_ff @(posedge p_clk) begin
    if (mem_we) mem[addr] <= rd_dat & in_byte;
    rd_dat <= mem[addr];
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      addr     <= '0;
      tx_sr    <= '0;
      miso_r   <= 1'b0;
      cmd_pp   <= 1'b0;
      wel      <= 1'b0;
      wip      <= 1'b0;
      wip_cnt  <= '0;
      prog_any <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (wip) begin
        wip_cnt <= wip_cnt - CW'(1);
        if (wip_cnt == CW'(1)) wip <= 1'b0;
      end
      if (css_rise) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        miso_r   <= 1'b0;
        prog_any <= 1'b0;
        if (prog_any) begin
          wip     <= 1'b1;
          wip_cnt <= CW'(PROG_CYCLES);
          wel     <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: if (css_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (sclk_rise) begin
            shreg   <= shift_nxt[SW-2:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              state   <= IGNORE;
              if (wip) begin
                if (in_byte == 8'h05) state <= STAT_OUT;
              end else begin
                case (in_byte)
                  8'h06: wel <= 1'b1;
                  8'h04: wel <= 1'b0;
                  8'h05: state <= STAT_OUT;
                  8'h03: begin state <= ADDR; cmd_pp <= 1'b0; end
                  8'h02: if (wel) begin state <= ADDR; cmd_pp <= 1'b1; end
                  default: cmd_err <= 1'b1;
                endcase
              end
            end
          end
          ADDR: if (sclk_rise) begin
            shreg   <= shift_nxt[SW-2:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              addr    <= shift_nxt[MEM_AW-1:0];
              state   <= cmd_pp ? DATA_IN : DATA_OUT;
            end
          end
          DATA_OUT, STAT_OUT: if (sclk_fall) begin
            // bit_cnt counts falling edges here; a zero count marks a byte boundary.
            if (bit_cnt[2:0] == 3'd0) begin
              miso_r <= nxt_byte[7];
              tx_sr  <= {nxt_byte[6:0], 1'b0};
              if (state == DATA_OUT) addr <= addr + MEM_AW'(1);
            end else begin
              miso_r <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
          end
          DATA_IN: if (sclk_rise) begin
            shreg   <= shift_nxt[SW-2:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              prog_any <= 1'b1;
              addr     <= {addr[MEM_AW-1:PAGE_AW], addr[PAGE_AW-1:0] + PAGE_AW'(1)};
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign s_miso = miso_r & ~s_css;
  assign busy   = wip;
endmodule

// File: tb/tb_spi_nor_responder.sv
// Directed bench for spi_nor_responder: a command table plus hand-written sequences for
// cmd_err, reads issued while programming, and reset in the middle of a read.
module tb_spi_nor_responder;
  localparam int HALF = 8;
  localparam int NREC = 25;

  logic p_clk = 1'b0;
  logic p_rst, s_clk, s_css, s_mosi;
  logic s_miso, busy, cmd_err;
  logic slow_miso, slow_busy, slow_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int err_hi = 0;
  logic err_prev = 1'b0;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] adr;
    logic        use_adr;
    logic [2:0]  n;
    logic [31:0] dat;
    logic        chk;
    logic [7:0]  busy_exp;
  } rec_t;

  rec_t recs [NREC];

  spi_nor_responder u_dut (
    .p_clk(p_clk), .p_rst(p_rst), .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi),
    .s_miso(s_miso), .busy(busy), .cmd_err(cmd_err)
  );

  // Long program time so a READ can be decoded while WIP is still set.
  spi_nor_responder #(.PROG_CYCLES(2000)) u_slow (
    .p_clk(p_clk), .p_rst(p_rst), .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi),
    .s_miso(slow_miso), .busy(slow_busy), .cmd_err(slow_err)
  );

  always #5 p_clk = ~p_clk;

  always @(negedge p_clk) begin
    if (cmd_err) err_hi++;
    if (cmd_err && !err_prev) err_pulses++;
    err_prev = cmd_err;
  end

  function automatic rec_t mk(input logic [7:0] op, input logic [23:0] adr, input logic use_adr,
                              input int n, input logic [31:0] dat, input logic chk, input int bz);
    rec_t r;
    r.op = op; r.adr = adr; r.use_adr = use_adr; r.n = 3'(n);
    r.dat = dat; r.chk = chk; r.busy_exp = 8'(bz);
    return r;
  endfunction

  task automatic check(input string what, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", what, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rxs);
    for (int i = 7; i >= 0; i--) begin
      s_mosi = tx[i];
      repeat (HALF) @(negedge p_clk);
      rx[i]  = s_miso;
      rxs[i] = slow_miso;
      s_clk  = 1'b1;
      repeat (HALF) @(negedge p_clk);
      s_clk  = 1'b0;
    end
  endtask

  task automatic cs_begin();
    s_css = 1'b0;
    repeat (HALF) @(negedge p_clk);
  endtask

  task automatic cs_end(output int bc);
    s_css = 1'b1;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge p_clk);
      if (busy) bc++;
    end
  endtask

  task automatic run_rec(input int idx, input rec_t r);
    logic [7:0] rx, rxs, tx;
    int bc;
    cs_begin();
    xfer(r.op, rx, rxs);
    if (r.use_adr) begin
      xfer(r.adr[23:16], rx, rxs);
      xfer(r.adr[15:8], rx, rxs);
      xfer(r.adr[7:0], rx, rxs);
    end
    for (int k = 0; k < int'(r.n); k++) begin
      tx = r.dat[31 - 8*k -: 8];
      xfer(r.chk ? 8'h00 : tx, rx, rxs);
      if (r.chk) check($sformatf("rec%0d byte%0d", idx, k), int'(rx), int'(tx));
    end
    cs_end(bc);
    check($sformatf("rec%0d busy_cycles", idx), bc, int'(r.busy_exp));
  endtask

  initial begin
    logic [7:0] rx, rxs;
    int bc, base_p, base_h;

    recs[0]  = mk(8'h05, 24'h0, 1'b0, 1, 32'h00000000, 1'b1, 0);
    recs[1]  = mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[2]  = mk(8'h05, 24'h0, 1'b0, 1, 32'h02000000, 1'b1, 0);
    recs[3]  = mk(8'h04, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[4]  = mk(8'h05, 24'h0, 1'b0, 1, 32'h00000000, 1'b1, 0);
    recs[5]  = mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[6]  = mk(8'h02, 24'h000010, 1'b1, 2, 32'hA53C0000, 1'b0, 64);
    recs[7]  = mk(8'h05, 24'h0, 1'b0, 1, 32'h00000000, 1'b1, 0);
    recs[8]  = mk(8'h03, 24'h000010, 1'b1, 3, 32'hA53CFF00, 1'b1, 0);
    recs[9]  = mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[10] = mk(8'h02, 24'h000010, 1'b1, 1, 32'h0F000000, 1'b0, 64);
    recs[11] = mk(8'h03, 24'h000010, 1'b1, 1, 32'h05000000, 1'b1, 0);
    recs[12] = mk(8'h02, 24'h000020, 1'b1, 1, 32'h00000000, 1'b0, 0);
    recs[13] = mk(8'h03, 24'h000020, 1'b1, 1, 32'hFF000000, 1'b1, 0);
    recs[14] = mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[15] = mk(8'h02, 24'h0000FE, 1'b1, 3, 32'h11223300, 1'b0, 64);
    recs[16] = mk(8'h03, 24'h0000FE, 1'b1, 3, 32'h1122FF00, 1'b1, 0);
    recs[17] = mk(8'h03, 24'h000000, 1'b1, 1, 32'h33000000, 1'b1, 0);
    recs[18] = mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[19] = mk(8'h02, 24'h0003FF, 1'b1, 1, 32'h5A000000, 1'b0, 64);
    recs[20] = mk(8'h03, 24'h0003FF, 1'b1, 2, 32'h5A330000, 1'b1, 0);
    recs[21] = mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[22] = mk(8'h05, 24'h0, 1'b0, 2, 32'h02020000, 1'b1, 0);
    recs[23] = mk(8'h04, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    recs[24] = mk(8'h03, 24'hFF0010, 1'b1, 1, 32'h05000000, 1'b1, 0);

    p_rst = 1'b1; s_clk = 1'b0; s_css = 1'b1; s_mosi = 1'b0;
    repeat (3) @(negedge p_clk);
    check("reset s_miso", int'(s_miso), 0);
    check("reset busy", int'(busy), 0);
    check("reset cmd_err", int'(cmd_err), 0);
    p_rst = 1'b0;
    repeat (10) @(negedge p_clk);

    base_p = err_pulses;
    for (int i = 0; i < NREC; i++) run_rec(i, recs[i]);
    check("no cmd_err on valid opcodes", err_pulses - base_p, 0);

    // Unsupported opcode: one single-cycle pulse, and nothing on s_miso afterwards.
    base_p = err_pulses; base_h = err_hi;
    cs_begin();
    xfer(8'hAB, rx, rxs);
    xfer(8'h00, rx, rxs);
    check("0xAB s_miso", int'(rx), 0);
    cs_end(bc);
    check("0xAB cmd_err pulses", err_pulses - base_p, 1);
    check("0xAB cmd_err high cycles", err_hi - base_h, 1);

    // READ decoded while the slow instance is still programming is ignored there.
    repeat (2100) @(negedge p_clk);
    run_rec(100, mk(8'h06, 24'h0, 1'b0, 0, 32'h0, 1'b0, 0));
    run_rec(101, mk(8'h02, 24'h000041, 1'b1, 1, 32'h81000000, 1'b0, 64));
    check("slow busy before READ", int'(slow_busy), 1);
    cs_begin();
    xfer(8'h03, rx, rxs); xfer(8'h00, rx, rxs); xfer(8'h00, rx, rxs); xfer(8'h41, rx, rxs);
    xfer(8'h00, rx, rxs);
    check("READ after busy data", int'(rx), 8'h81);
    check("READ while busy s_miso", int'(rxs), 0);
    cs_end(bc);

    // Reset in the middle of a READ whose next byte starts with a 1.
    cs_begin();
    xfer(8'h03, rx, rxs); xfer(8'h00, rx, rxs); xfer(8'h00, rx, rxs); xfer(8'h12, rx, rxs);
    xfer(8'h00, rx, rxs);
    check("mid-READ first byte", int'(rx), 8'hFF);
    repeat (6) @(negedge p_clk);
    check("mid-READ next MSB", int'(s_miso), 1);
    p_rst = 1'b1;
    @(negedge p_clk);
    check("mid-READ reset s_miso", int'(s_miso), 0);
    check("mid-READ reset busy", int'(busy), 0);
    s_css = 1'b1;
    repeat (4) @(negedge p_clk);
    p_rst = 1'b0;
    repeat (8) @(negedge p_clk);
    run_rec(200, mk(8'h03, 24'h000010, 1'b1, 1, 32'h05000000, 1'b1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
